inout_sram_reader: RTL

- Read-side stream engine for the 384 kB in/out activation SRAM (six 64 kB banks, 196608 16-bit words, 18-bit word address, 1-cycle read latency).
- On a start pulse it reads a contiguous word range and presents it as a valid/ready stream to the downstream PE-array feeder.
- A small prefetch FIFO absorbs backpressure, so SRAM reads never get lost.
- Read-only: the SRAM write enable is held inactive.

---
 rtl/inout_sram_reader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/inout_sram_reader.sv
// ---------------------------------------------------------------------------
// inout_sram_reader
//   Read-side stream engine for the in/out activation SRAM. A start pulse
//   requests a contiguous word range; the engine issues one SRAM read per
//   cycle while the prefetch FIFO has room. It then presents the returned
//   words as a valid/ready stream. The SRAM is never written.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      request pulse, sampled only when idle
//   base_addr  first word address, sampled with start
//   length     word count, sampled with start
//   busy       transfer in progress (cycle after accept .. done)
//   done       one-cycle pulse after the final word is accepted downstream
//   err        one-cycle pulse when a request is rejected
//   mem_cs     SRAM chip select (read issue)
//   mem_oe     SRAM output enable (cycle after the issue)
//   mem_web    SRAM write enable, active low, tied inactive
//   mem_addr   SRAM word address
//   mem_rdata  SRAM read data, valid the cycle after the issue
//   out_valid  stream word valid
//   out_ready  downstream ready
//   out_data   stream word
//   out_last   final word of the transfer
// ---------------------------------------------------------------------------
module inout_sram_reader #(
   parameter int DEPTH = 4,
   parameter int WORDS = 196608
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [17:0] base_addr,
   input  logic [17:0] length,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_cs,
   output logic        mem_oe,
   output logic        mem_web,
   output logic [17:0] mem_addr,
   input  logic [15:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [18:0]   WORDS_C = 19'(WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_r;
   logic [17:0]   rd_addr_r;
   logic [17:0]   issue_cnt_r;
   logic [17:0]   pop_cnt_r;
   logic          inflight_r;
   logic [15:0]   fifo_mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          busy_r;
   logic          done_r;
   logic          err_r;

   logic          issue_s;
   logic          push_s;
   logic          pop_s;
   logic          req_bad_s;
   logic [CW-1:0] level_s;
   logic [18:0]   req_end_s;

   // Issue/push/pop decisions and request validation from registered state
   always_comb begin
      // Words stored plus the one still returning from the SRAM. Issuing only
      // below DEPTH guarantees every returning word has a FIFO slot.
      level_s   = count_r + {{(CW-1){1'b0}}, inflight_r};
      issue_s   = (state_r == RUN) && (issue_cnt_r != 18'd0) && (level_s < DEPTH_C);
      push_s    = inflight_r;
      pop_s     = (count_r != {CW{1'b0}}) && out_ready;
      // 19-bit sum so a range ending exactly at the last word is accepted
      req_end_s = {1'b0, base_addr} + {1'b0, length};
      req_bad_s = (length == 18'd0) || (req_end_s > WORDS_C);
   end

   assign mem_cs    = issue_s;
   assign mem_addr  = issue_s ? rd_addr_r : 18'd0;
   assign mem_oe    = inflight_r;
   assign mem_web   = 1'b1;
   assign out_valid = (count_r != {CW{1'b0}});
   assign out_data  = fifo_mem_r[rd_ptr_r];
   assign out_last  = out_valid && (pop_cnt_r == 18'd1);
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

   // Prefetch FIFO storage: capture the word returning from the SRAM
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= mem_rdata;
      end
   end

   // Control FSM, address/count registers, FIFO pointers and status pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rd_addr_r   <= 18'd0;
         issue_cnt_r <= 18'd0;
         pop_cnt_r   <= 18'd0;
         inflight_r  <= 1'b0;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         inflight_r <= issue_s;

         if (issue_s) begin
            rd_addr_r   <= rd_addr_r + 18'd1;
            issue_cnt_r <= issue_cnt_r - 18'd1;
         end

         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            pop_cnt_r <= pop_cnt_r - 18'd1;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase

         case (state_r)
            IDLE: begin
               if (start) begin
                  if (req_bad_s) begin
                     err_r <= 1'b1;
                  end else begin
                     rd_addr_r   <= base_addr;
                     issue_cnt_r <= length;
                     pop_cnt_r   <= length;
                     busy_r      <= 1'b1;
                     state_r     <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue_s && (issue_cnt_r == 18'd1)) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_s && (pop_cnt_r == 18'd1)) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
